// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ready bus between fetch_stage and the instruction memory.
// master: fetch stage (drives address/read); slave: memory (drives data/ready).
interface fetch_stage_if;
  logic [31:0] imem_address;
  logic        imem_read;
  logic [31:0] imem_data;
  logic        imem_ready;

  modport master (
    output imem_address,
    output imem_read,
    input  imem_data,
    input  imem_ready
  );

  modport slave (
    input  imem_address,
    input  imem_read,
    output imem_data,
    output imem_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage with IF/ID pipeline register.
// Holds the PC, runs the imem request/ready handshake, applies branch (EX) and
// jump (ID) redirects, and parks a word fetched under stall in a hold buffer.
// Optional macro FETCH_COUNTERS_EN adds fetch_count / bubble_count outputs.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [31:0]          branch_target,
  input  logic                 jump,
  fetch_stage_if.master        imem,
  output logic [31:0]          if_id_instruction,
  output logic [31:0]          if_id_pc_plus4,
  output logic                 if_id_valid,
  output logic [5:0]           opcode
`ifdef FETCH_COUNTERS_EN
  ,
  output logic [31:0]          fetch_count,
  output logic [31:0]          bubble_count
`endif
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        run_q, run_d;            // 0 until the first edge after reset release
  logic [31:0] pc_q, pc_d;
  logic [31:0] saved_target_q, saved_target_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc4_q, buf_pc4_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;

  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic [31:0] redirect_pc;
  logic        take_jump;
  logic        redirect;
  logic        load_valid;
  logic        write_bubble;

`ifdef FETCH_COUNTERS_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] bubble_count_q, bubble_count_d;
`endif

  // Redirect selection: branch beats jump; jump needs a valid, unstalled IF/ID.
  always_comb begin
    pc_plus4    = pc_q + 32'd4;
    jump_target = {ifid_pc4_q[31:28], ifid_instr_q[25:0], 2'b00};
    take_jump   = jump && ifid_valid_q && !stall;
    redirect    = branch_taken || take_jump;
    redirect_pc = branch_taken ? branch_target : jump_target;
  end

  // Next-state, PC, hold buffer and IF/ID register update.
  always_comb begin
    state_d        = state_q;
    run_d          = 1'b1;
    pc_d           = pc_q;
    saved_target_d = saved_target_q;
    buf_instr_d    = buf_instr_q;
    buf_pc4_d      = buf_pc4_q;
    ifid_instr_d   = ifid_instr_q;
    ifid_pc4_d     = ifid_pc4_q;
    ifid_valid_d   = ifid_valid_q;
    load_valid     = 1'b0;
    write_bubble   = 1'b0;

    if (run_q) begin
      unique case (state_q)
        FETCH: begin
          if (redirect) begin
            write_bubble = 1'b1;
            if (imem.imem_ready) begin
              pc_d = redirect_pc;
            end else begin
              // address must stay put until the memory answers
              saved_target_d = redirect_pc;
              state_d        = DISCARD;
            end
          end else if (imem.imem_ready) begin
            pc_d = pc_plus4;
            if (!stall) begin
              ifid_instr_d = imem.imem_data;
              ifid_pc4_d   = pc_plus4;
              load_valid   = 1'b1;
            end else begin
              buf_instr_d = imem.imem_data;
              buf_pc4_d   = pc_plus4;
              state_d     = HOLD;
            end
          end else if (!stall) begin
            write_bubble = 1'b1;
          end
        end

        HOLD: begin
          if (redirect) begin
            pc_d         = redirect_pc;
            write_bubble = 1'b1;
            state_d      = FETCH;
          end else if (!stall) begin
            ifid_instr_d = buf_instr_q;
            ifid_pc4_d   = buf_pc4_q;
            load_valid   = 1'b1;
            state_d      = FETCH;
          end
        end

        DISCARD: begin
          write_bubble = 1'b1;
          if (branch_taken) begin
            saved_target_d = branch_target;
          end
          if (imem.imem_ready) begin
            pc_d    = branch_taken ? branch_target : saved_target_q;
            state_d = FETCH;
          end
        end

        default: begin
          state_d = FETCH;
        end
      endcase
    end

    if (load_valid) begin
      ifid_valid_d = 1'b1;
    end else if (write_bubble) begin
      ifid_valid_d = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= FETCH;
      run_q          <= 1'b0;
      pc_q           <= RESET_PC;
      saved_target_q <= '0;
      buf_instr_q    <= '0;
      buf_pc4_q      <= '0;
      ifid_instr_q   <= '0;
      ifid_pc4_q     <= '0;
      ifid_valid_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      run_q          <= run_d;
      pc_q           <= pc_d;
      saved_target_q <= saved_target_d;
      buf_instr_q    <= buf_instr_d;
      buf_pc4_q      <= buf_pc4_d;
      ifid_instr_q   <= ifid_instr_d;
      ifid_pc4_q     <= ifid_pc4_d;
      ifid_valid_q   <= ifid_valid_d;
    end
  end

`ifdef FETCH_COUNTERS_EN
  // Counter increments: valid loads, and bubbles written while not stalled.
  always_comb begin
    fetch_count_d  = fetch_count_q + {31'd0, load_valid};
    bubble_count_d = bubble_count_q + {31'd0, write_bubble && !stall};
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_count_q  <= '0;
      bubble_count_q <= '0;
    end else begin
      fetch_count_q  <= fetch_count_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign fetch_count  = fetch_count_q;
  assign bubble_count = bubble_count_q;
`endif

  assign imem.imem_read    = run_q && (state_q != HOLD);
  assign imem.imem_address = pc_q;
  assign if_id_instruction = ifid_instr_q;
  assign if_id_pc_plus4    = ifid_pc4_q;
  assign if_id_valid       = ifid_valid_q;
  assign opcode            = ifid_instr_q[31:26];

endmodule
